// File: rtl/wvb_reader_if.sv
// wvb_reader_if: header/sample buffer port and output stream of the waveform reader.
interface wvb_reader_if;
  logic [79:0] hdr_data;
  logic        hdr_rdreq;
  logic [21:0] wvb_data;
  logic        wvb_rdreq;
  logic        wvb_rddone;
  logic [31:0] dout;
  logic        dout_valid;
  logic        dout_ready;
  modport master (
    input  hdr_data, wvb_data, dout_ready,
    output hdr_rdreq, wvb_rdreq, wvb_rddone, dout, dout_valid
  );
  modport slave (
    output hdr_data, wvb_data, dout_ready,
    input  hdr_rdreq, wvb_rdreq, wvb_rddone, dout, dout_valid
  );
endinterface

// File: rtl/wvb_reader.sv
// wvb_reader: pops a header and its waveform from the wvb buffer and streams them through a FWFT FIFO.
// Define WVB_RD_TRAILER_EN to append a sample-count/XOR trailer word after each waveform.
module wvb_reader #(
  parameter int HDR_LAT     = 2,
  parameter int RD_LAT      = 2,
  parameter int OFIFO_DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enable,
  input  logic [9:0]   n_wvf_in_buf,
  wvb_reader_if.master bus,
  output logic         busy
);
  localparam int CW = $clog2(OFIFO_DEPTH + RD_LAT + 2);
  localparam int PW = OFIFO_DEPTH > 1 ? $clog2(OFIFO_DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH = CW'(OFIFO_DEPTH);
  localparam logic [15:0] HL = 16'(HDR_LAT - 1);
  typedef enum logic [2:0] {
    S_IDLE, S_HDR_WAIT, S_HDR_EMIT, S_RD, S_DRAIN,
`ifdef WVB_RD_TRAILER_EN
    S_TRL,
`endif
    S_DONE
  } state_t;
  state_t state, nxt;
  logic [15:0] cnt;
  logic [79:0] hdr;
  logic [12:0] issued, wfm_len;
  logic [RD_LAT-1:0] pipe;
  logic [CW-1:0] fifo_cnt, inflight;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [31:0] mem [OFIFO_DEPTH];
  logic [31:0] pdata, h0, h1, h2;
  logic push, pop, space, sample, hdr_req, rd_req, done;
  function automatic logic [PW-1:0] nx(input logic [PW-1:0] p);
    return p == PW'(OFIFO_DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  assign wfm_len = {1'b0, hdr[19:8] - hdr[31:20]} + 13'd1;
  assign h0 = {8'h90, hdr[7:6], hdr[5], hdr[4:0], 3'b0, wfm_len};
  assign h1 = hdr[79:48];
  assign h2 = {hdr[47:32], 4'b0, hdr[31:20]};
  assign space = fifo_cnt < DEPTH;
  // a word arrives RD_LAT cycles after its request; the pipe tail marks that cycle
  assign sample = pipe[RD_LAT-1];
  assign pop = bus.dout_valid && bus.dout_ready;
`ifdef WVB_RD_TRAILER_EN
  logic [21:0] xr;
  logic [12:0] scnt;
  always_ff @(posedge clk)
    if (!rst || state == S_IDLE) begin
      xr <= '0;
      scnt <= '0;
    end else if (sample) begin
      xr <= xr ^ bus.wvb_data;
      scnt <= scnt + 13'd1;
    end
`endif
  always_comb begin
    nxt = state;
    hdr_req = 1'b0;
    rd_req = 1'b0;
    done = 1'b0;
    push = sample;
    pdata = {10'b0, bus.wvb_data};
    case (state)
      S_IDLE: if (rst && enable && n_wvf_in_buf != '0) begin
        hdr_req = 1'b1;
        nxt = S_HDR_WAIT;
      end
      S_HDR_WAIT: if (cnt == HL) nxt = S_HDR_EMIT;
      S_HDR_EMIT: begin
        push = space;
        pdata = cnt == 16'd0 ? h0 : cnt == 16'd1 ? h1 : h2;
        if (space && cnt == 16'd2) nxt = S_RD;
      end
      S_RD: begin
        // words already requested are counted against the FIFO so the sink can never cause overflow
        rd_req = rst && issued < wfm_len && fifo_cnt + inflight < DEPTH;
        if (issued == wfm_len) nxt = S_DRAIN;
      end
`ifdef WVB_RD_TRAILER_EN
      S_DRAIN: if (inflight == '0) nxt = S_TRL;
      S_TRL: begin
        push = space;
        pdata = {8'hE0, 2'b0, xr} ^ {19'b0, scnt};
        if (space) nxt = S_DONE;
      end
`else
      S_DRAIN: if (inflight == '0) nxt = S_DONE;
`endif
      S_DONE: begin
        done = rst;
        nxt = S_IDLE;
      end
      default: nxt = S_IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (!rst) begin
      state <= S_IDLE;
      cnt <= '0;
      hdr <= '0;
      issued <= '0;
      pipe <= '0;
      inflight <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      fifo_cnt <= '0;
    end else begin
      state <= nxt;
      cnt <= state != nxt ? '0 : cnt + 16'(state == S_HDR_WAIT || (state == S_HDR_EMIT && push));
      if (state == S_HDR_WAIT && cnt == HL) hdr <= bus.hdr_data;
      issued <= state == S_IDLE ? '0 : issued + 13'(rd_req);
      pipe <= RD_LAT'({pipe, rd_req});
      inflight <= inflight + CW'(rd_req) - CW'(sample);
      if (push) wr_ptr <= nx(wr_ptr);
      if (pop) rd_ptr <= nx(rd_ptr);
      fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
    end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= pdata;
  assign bus.hdr_rdreq = hdr_req;
  assign bus.wvb_rdreq = rd_req;
  assign bus.wvb_rddone = done;
  assign bus.dout_valid = fifo_cnt != '0;
  assign bus.dout = bus.dout_valid ? mem[rd_ptr] : '0;
  assign busy = state != S_IDLE;
endmodule

// File: tb/tb_wvb_reader.sv
// tb_wvb_reader: randomized readouts of wvb_reader checked against a queue-based stream model.
module tb_wvb_reader;
  localparam int DEPTH = 8;
`ifdef WVB_RD_TRAILER_EN
  localparam int TR = 1;
`else
  localparam int TR = 0;
`endif
  typedef struct {
    logic [11:0] start;
    logic [11:0] stop;
    int mode;
    int len;
  } vec_t;
  logic clk = 0, rst = 0, enable = 0;
  logic [9:0] n_wvf_in_buf = 0;
  logic busy;
  wvb_reader_if bus ();
  wvb_reader #(.HDR_LAT(2), .RD_LAT(2), .OFIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .enable(enable), .n_wvf_in_buf(n_wvf_in_buf), .bus(bus), .busy(busy)
  );
  always #5 clk = ~clk;
  int total = 0, bad = 0;
  int hreq_n = 0, wreq_tot = 0, done_n = 0, pop_n = 0, entered = 0;
  int ready_mode = 0, rc = 0, cyc = 0;
  logic [79:0] hdr_q[$];
  logic [21:0] samp_q[$];
  logic [31:0] exp_q[$];
  logic [79:0] hslot[4];
  logic [21:0] wslot[4];
  logic hslot_v[4], wslot_v[4];
  logic pv = 0, pr = 0;
  logic [31:0] pd = 0;
  vec_t tbl[6];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask
  // reference: queue the header and samples for the buffer and the exact expected stream
  function automatic int build(input logic [11:0] start, input logic [11:0] stop);
    int len = ((int'(stop) - int'(start) + 4096) % 4096) + 1;
    logic [47:0] ltc = {16'($urandom()), $urandom()};
    logic [1:0] trig = 2'($urandom());
    logic cr = 1'($urandom());
    logic [4:0] pre = 5'($urandom());
    logic [21:0] x = '0, s;
    hdr_q.push_back({ltc, start, stop, trig, cr, pre});
    exp_q.push_back({8'h90, trig, cr, pre, 3'b0, 13'(len)});
    exp_q.push_back(ltc[47:16]);
    exp_q.push_back({ltc[15:0], 4'b0, start});
    for (int i = 0; i < len; i++) begin
      s = 22'($urandom());
      if (i == len / 2) s[0] = 1'b1;
      samp_q.push_back(s);
      exp_q.push_back({10'b0, s});
      x ^= s;
    end
    if (TR != 0) exp_q.push_back({8'hE0, 2'b0, x} ^ 32'(len));
    return len;
  endfunction
  // buffer model: header/sample answer appears exactly two cycles after its request
  initial begin
    bus.hdr_data = '0;
    bus.wvb_data = '0;
    for (int i = 0; i < 4; i++) begin
      hslot_v[i] = 0;
      wslot_v[i] = 0;
    end
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      bus.hdr_data = hslot_v[cyc & 3] ? hslot[cyc & 3] : {$urandom(), $urandom(), 16'($urandom())};
      bus.wvb_data = wslot_v[cyc & 3] ? wslot[cyc & 3] : 22'($urandom());
      hslot_v[cyc & 3] = 0;
      wslot_v[cyc & 3] = 0;
      @(negedge clk);
      if (bus.hdr_rdreq) begin
        hslot[(cyc + 2) & 3] = hdr_q.size() != 0 ? hdr_q.pop_front() : '0;
        hslot_v[(cyc + 2) & 3] = 1;
      end
      if (bus.wvb_rdreq) begin
        wslot[(cyc + 2) & 3] = samp_q.size() != 0 ? samp_q.pop_front() : '0;
        wslot_v[(cyc + 2) & 3] = 1;
      end
    end
  end
  initial begin
    bus.dout_ready = 0;
    forever begin
      @(posedge clk);
      #1;
      rc++;
      bus.dout_ready = ready_mode == 0 ? 1'b1 : ready_mode == 1 ? (rc % 3 == 0) : 1'($urandom_range(0, 1));
    end
  end
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) pv = 0;
      else begin
        if (pv && !pr) begin
          chk("stall_valid", bus.dout_valid, 1);
          chk("stall_data", bus.dout, pd);
        end
        if (bus.hdr_rdreq) begin
          hreq_n++;
          entered += 3;
        end
        if (bus.wvb_rdreq) begin
          wreq_tot++;
          chk("fifo_bound", (entered + wreq_tot - pop_n) <= DEPTH, 1);
        end
        if (bus.wvb_rddone) begin
          done_n++;
          entered += TR;
        end
        if (bus.dout_valid && bus.dout_ready) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL extra_word: got %0h expected none", bus.dout);
          end else chk("stream", bus.dout, exp_q.pop_front());
          pop_n++;
        end
        pv = bus.dout_valid;
        pr = bus.dout_ready;
        pd = bus.dout;
      end
    end
  end
  task automatic readout(input logic [11:0] start, input logic [11:0] stop, input int mode, input int exp_len, input string tag);
    int w0 = wreq_tot, d0 = done_n, h0 = hreq_n, p0 = pop_n;
    ready_mode = mode;
    void'(build(start, stop));
    n_wvf_in_buf = 1;
    enable = 1;
    for (int i = 0; i < 20 && hreq_n == h0; i++) tick();
    enable = 0;
    for (int i = 0; i < 20000 && done_n == d0; i++) tick();
    chk({tag, " rddone"}, done_n - d0, 1);
    chk({tag, " busy_after"}, busy, 0);
    for (int i = 0; i < 5000 && exp_q.size() != 0; i++) tick();
    chk({tag, " rdreqs"}, wreq_tot - w0, exp_len);
    chk({tag, " words"}, pop_n - p0, 3 + exp_len + TR);
    chk({tag, " hdr_rdreqs"}, hreq_n - h0, 1);
    n_wvf_in_buf = 0;
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    int w0, d0, h0, p0;
    tbl[0] = '{12'd0, 12'd9, 0, 10};
    tbl[1] = '{12'd5, 12'd4, 0, 4096};
    tbl[2] = '{12'd100, 12'd119, 1, 20};
    tbl[3] = '{12'd4095, 12'd0, 2, 2};
    tbl[4] = '{12'd7, 12'd7, 2, 1};
    tbl[5] = '{12'd10, 12'd40, 1, 31};
    enable = 1;
    n_wvf_in_buf = 1;
    tick(3);
    chk("rst_hdr_rdreq", bus.hdr_rdreq, 0);
    chk("rst_wvb_rdreq", bus.wvb_rdreq, 0);
    chk("rst_rddone", bus.wvb_rddone, 0);
    chk("rst_dout_valid", bus.dout_valid, 0);
    chk("rst_dout", bus.dout, 0);
    chk("rst_busy", busy, 0);
    enable = 0;
    n_wvf_in_buf = 0;
    rst = 1;
    tick(2);
    chk("idle_busy", busy, 0);
    for (int k = 0; k < 6; k++) readout(tbl[k].start, tbl[k].stop, tbl[k].mode, tbl[k].len, $sformatf("vec%0d", k));
    ready_mode = 2;
    void'(build(12'd0, 12'd49));
    w0 = wreq_tot;
    d0 = done_n;
    n_wvf_in_buf = 1;
    enable = 1;
    for (int i = 0; i < 200 && wreq_tot - w0 < 10; i++) tick();
    rst = 0;
    tick();
    chk("mid_rst_hdr_rdreq", bus.hdr_rdreq, 0);
    chk("mid_rst_wvb_rdreq", bus.wvb_rdreq, 0);
    chk("mid_rst_rddone", bus.wvb_rddone, 0);
    chk("mid_rst_dout_valid", bus.dout_valid, 0);
    chk("mid_rst_dout", bus.dout, 0);
    chk("mid_rst_busy", busy, 0);
    tick(3);
    chk("mid_rst_no_rddone", done_n - d0, 0);
    chk("mid_rst_held_hdr_rdreq", bus.hdr_rdreq, 0);
    enable = 0;
    exp_q.delete();
    samp_q.delete();
    hdr_q.delete();
    for (int i = 0; i < 4; i++) begin
      hslot_v[i] = 0;
      wslot_v[i] = 0;
    end
    entered = 0;
    wreq_tot = 0;
    pop_n = 0;
    rst = 1;
    tick();
    readout(12'd7, 12'd20, 1, 14, "post_rst");
    ready_mode = 0;
    void'(build(12'd1, 12'd5));
    void'(build(12'd2, 12'd3));
    w0 = wreq_tot;
    d0 = done_n;
    h0 = hreq_n;
    p0 = pop_n;
    n_wvf_in_buf = 2;
    enable = 1;
    for (int i = 0; i < 20 && hreq_n == h0; i++) tick();
    enable = 0;
    for (int i = 0; i < 500 && done_n == d0; i++) tick();
    tick(30);
    chk("hold_hdr_rdreqs", hreq_n - h0, 1);
    chk("hold_rddone", done_n - d0, 1);
    chk("hold_pending_words", exp_q.size(), 5 + TR);
    enable = 1;
    for (int i = 0; i < 500 && done_n - d0 < 2; i++) tick();
    enable = 0;
    for (int i = 0; i < 500 && exp_q.size() != 0; i++) tick();
    chk("second_hdr_rdreqs", hreq_n - h0, 2);
    chk("second_rddone", done_n - d0, 2);
    chk("second_rdreqs", wreq_tot - w0, 7);
    chk("second_words", pop_n - p0, 13 + 2 * TR);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/wvb_reader.md
WVB_READER -- requirements
Module: wvb_reader

Interface
REQ-001 Parameter HDR_LAT, default 2: cycles from hdr_rdreq pulse to valid hdr_data.
REQ-002 Parameter RD_LAT, default 2: cycles from wvb_rdreq high to the corresponding valid wvb_data word.
REQ-003 Parameter OFIFO_DEPTH, default 8: output FIFO depth in words; must exceed RD_LAT+1.
REQ-004 Port: clk  in  1  clock; all logic on rising edge.
REQ-005 Port: rst  in  1  reset, synchronous, active-low.
REQ-006 Port: enable  in  1  permits starting a new waveform readout.
REQ-007 Port: n_wvf_in_buf  in  10  waveforms stored in the buffer.
REQ-008 Port: hdr_data  in  80  header bundle: [79:32] evt_ltc, [31:20] start_addr, [19:8] stop_addr, [7:6] trig_src, [5] cnst_run, [4:0] pre_conf.
REQ-009 Port: hdr_rdreq  out  1  one-cycle header pop.
REQ-010 Port: wvb_data  in  22  sample word: [21:14] discr, [13:2] adc, [1] tot, [0] eoe.
REQ-011 Port: wvb_rdreq  out  1  sample pop, one word per high cycle.
REQ-012 Port: wvb_rddone  out  1  one-cycle pulse that releases the waveform in the buffer.
REQ-013 Port: dout  out  32  output stream word.
REQ-014 Port: dout_valid  out  1  dout holds a valid word.
REQ-015 Port: dout_ready  in  1  sink accepts; a word transfers when dout_valid and dout_ready are both high.
REQ-016 Port: busy  out  1  high in any state other than S_IDLE.

Function
REQ-017 FSM states: S_IDLE, S_HDR_WAIT, S_HDR_EMIT, S_RD, S_DRAIN, S_TRL, S_DONE.
REQ-018 S_IDLE: when enable=1 and n_wvf_in_buf>0, pulse hdr_rdreq for one cycle and go to S_HDR_WAIT; otherwise remain.
REQ-019 S_HDR_WAIT: count HDR_LAT cycles, capture hdr_data, then go to S_HDR_EMIT.
REQ-020 wfm_len is 13 bits, equal to ((stop_addr - start_addr) mod 4096) + 1, range 1..4096; stop_addr = start_addr - 1 mod 4096 gives 4096.
REQ-021 S_HDR_EMIT pushes three words into the output FIFO, one per cycle while space exists:
- H0 = {8'h90, trig_src, cnst_run, pre_conf, 3'b0, wfm_len}
- H1 = evt_ltc[47:16]
- H2 = {evt_ltc[15:0], 4'b0, start_addr}
It then goes to S_RD.
REQ-022 S_RD: assert wvb_rdreq only while issued < wfm_len and (fifo_count + in_flight) < OFIFO_DEPTH; data words never overflow the FIFO regardless of dout_ready.
REQ-023 Each returned sample is pushed as {10'b0, wvb_data} exactly RD_LAT cycles after its rdreq cycle.
REQ-024 After wfm_len rdreqs have been issued, go to S_DRAIN.
REQ-025 S_DRAIN: wait until in_flight=0, then go to S_TRL if the trailer feature is compiled in, else to S_DONE.
REQ-026 S_DONE: pulse wvb_rddone for one cycle, then return to S_IDLE; at least one S_IDLE cycle separates readouts.
REQ-027 Deasserting enable mid-readout does not abort; the current waveform completes, then the FSM holds in S_IDLE.
REQ-028 The output FIFO is first-word-fall-through.
- dout_valid = (fifo_count > 0).
- dout is stable while dout_valid=1 and dout_ready=0.
- A push and a pop in the same cycle leave fifo_count unchanged.
REQ-029 A sample with eoe=1 before the last issued word is forwarded unchanged; the sample count is governed by wfm_len only.

Reset
REQ-030 On rst=0 at a clock edge:
- FSM goes to S_IDLE; all counters and the FIFO are cleared.
- hdr_rdreq, wvb_rdreq, wvb_rddone, dout_valid and busy are 0; dout is 0.
REQ-031 Reset mid-readout discards in-flight data and issues no wvb_rddone.

Configuration
REQ-032 Macro WVB_RD_TRAILER_EN, when defined: S_TRL pushes one trailer word {8'hE0, 11'b0, sample_count[12:0]}, XOR-folded with the running 22-bit XOR of all samples in bits [21:0] (trailer = {8'hE0, 2'b0, xor22} ^ {19'b0, count}), then goes to S_DONE.
REQ-033 WVB_RD_TRAILER_EN undefined: S_TRL and the XOR logic are absent; the stream is 3 + wfm_len words.

Verification
REQ-034 Header start=0, stop=9, dout_ready=1 -> H0 wfm_len=10, then 10 sample words in buffer order, one wvb_rddone pulse, busy falls after it.
REQ-035 start=5, stop=4 -> wfm_len=4096, exactly 4096 rdreq cycles, 4099 words (4100 with the trailer).
REQ-036 dout_ready toggled 1-of-3 cycles, wfm_len=20 -> no word lost or duplicated, fifo_count never exceeds 8, dout stable while stalled.
REQ-037 rst=0 asserted during S_RD of a 50-sample waveform -> all outputs 0 next cycle, no rddone; after rst=1 and n_wvf_in_buf>0, a fresh readout starts with hdr_rdreq.
REQ-038 n_wvf_in_buf=2 with enable dropped during the first readout -> the first completes with rddone, no second hdr_rdreq until enable=1.
